// File: rtl/ltc2308_pkg.sv
// Shared types and helpers for the LTC2308 scan controller.
package ltc2308_pkg;

    localparam int ADC_BITS = 12;
    localparam int CFG_BITS = 6;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHIFT,
        DONE
    } state_t;

    // {S/D, O/S, S1, S0, UNI, SLP}, single-ended, sleep off
    function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] ch, input logic uni);
        return {1'b1, ch[0], ch[2], ch[1], uni, 1'b0};
    endfunction

endpackage

// File: rtl/adc_rate_tick.sv
// Fractional rate generator: pulses tick RATE times per CLK_RATE clocks on average.
module adc_rate_tick #(
    parameter int CLK_RATE = 50000000,
    parameter int RATE     = 96000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam logic [31:0] STEP = 32'(RATE);
    localparam logic [31:0] WRAP = 32'(CLK_RATE);

    logic [31:0] acc;
    logic [31:0] acc_sum;

    assign acc_sum = acc + STEP;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (acc_sum >= WRAP) begin
            acc  <= acc_sum - WRAP;
            tick <= 1'b1;
        end else begin
            acc  <= acc_sum;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/ltc2308_scan_ctrl.sv
// Round-robin LTC2308 conversion scheduler with pipelined channel addressing.
//
// state | meaning
// IDLE  | wait for a pending rate tick and a non-empty channel mask
// CONV  | hold CONVST high for TCONV cycles
// SHIFT | 12 SCK periods: read previous conversion, send next channel's config
// DONE  | publish sample (once primed), advance round-robin pointer
module ltc2308_scan_ctrl
    import ltc2308_pkg::*;
#(
    parameter int CLK_RATE = 50000000,
    parameter int ADC_RATE = 96000,
    parameter int SCK_HALF = 2,
    parameter int TCONV    = 80
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          ch_mask,
    input  logic                uni,
    output logic                adc_convst,
    output logic                adc_sck,
    output logic                adc_sdi,
    input  logic                adc_sdo,
    output logic [ADC_BITS-1:0] dout,
    output logic [2:0]          dout_ch,
    output logic                dout_valid,
    output logic                busy,
    output logic                overrun
);

    localparam logic [15:0] TCONV_LD = 16'(TCONV - 1);
    localparam logic [15:0] HALF_LD  = 16'(SCK_HALF - 1);

    state_t              state, state_n;
    logic [15:0]         tmr, tmr_n;
    logic [3:0]          bit_idx, bit_n, bit_dec;
    logic                ph, ph_n;
    logic [ADC_BITS-1:0] shreg, shreg_n;
    logic [CFG_BITS-1:0] cfg_q, cfg_n, cfg_next;
    logic [ADC_BITS-1:0] stream;
    logic [2:0]          cur_ch, cur_n, nxt_ch, nxt_n;
    logic                primed, primed_n;
    logic                pending, pending_n;
    logic                take;
    logic                tick;
    logic                convst_n, sck_n, sdi_n, valid_n, overrun_n;
    logic [ADC_BITS-1:0] dout_n;
    logic [2:0]          dout_ch_n;

    // First set mask bit strictly after 'from', wrapping; 'from' itself if it is the only one
    function automatic logic [2:0] next_set(input logic [7:0] mask, input logic [2:0] from);
        logic [2:0] idx;
        next_set = from;
        for (int i = 8; i >= 1; i--) begin
            idx = from + 3'(i);
            if (mask[idx]) next_set = idx;
        end
    endfunction

    adc_rate_tick #(
        .CLK_RATE (CLK_RATE),
        .RATE     (ADC_RATE)
    ) u_rate (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign busy     = (state != IDLE);
    assign stream   = {cfg_q, {(ADC_BITS-CFG_BITS){1'b0}}};
    assign bit_dec  = bit_idx - 4'd1;
    assign cfg_next = cfg_word(nxt_ch, uni);

    always_comb begin
        state_n   = state;
        tmr_n     = tmr;
        bit_n     = bit_idx;
        ph_n      = ph;
        shreg_n   = shreg;
        cfg_n     = cfg_q;
        cur_n     = cur_ch;
        nxt_n     = nxt_ch;
        primed_n  = primed;
        take      = 1'b0;
        convst_n  = adc_convst;
        sck_n     = adc_sck;
        sdi_n     = adc_sdi;
        dout_n    = dout;
        dout_ch_n = dout_ch;
        valid_n   = 1'b0;

        case (state)
            IDLE: begin
                if (ch_mask == 8'h00) begin
                    primed_n = 1'b0;
                end else if (pending) begin
                    take     = 1'b1;
                    state_n  = CONV;
                    convst_n = 1'b1;
                    tmr_n    = TCONV_LD;
                    if (!primed) nxt_n = next_set(ch_mask, 3'd7);
                end
            end
            CONV: begin
                if (tmr == 16'd0) begin
                    state_n  = SHIFT;
                    convst_n = 1'b0;
                    tmr_n    = HALF_LD;
                    bit_n    = 4'd11;
                    ph_n     = 1'b0;
                    cfg_n    = cfg_next;
                    sdi_n    = cfg_next[CFG_BITS-1];
                end else begin
                    tmr_n = tmr - 16'd1;
                end
            end
            SHIFT: begin
                if (tmr != 16'd0) begin
                    tmr_n = tmr - 16'd1;
                end else begin
                    tmr_n = HALF_LD;
                    if (!ph) begin
                        // last low cycle: capture sdo, raise SCK on this edge
                        shreg_n = {shreg[ADC_BITS-2:0], adc_sdo};
                        sck_n   = 1'b1;
                        ph_n    = 1'b1;
                    end else begin
                        sck_n = 1'b0;
                        ph_n  = 1'b0;
                        if (bit_idx == 4'd0) begin
                            state_n = DONE;
                            sdi_n   = 1'b0;
                        end else begin
                            bit_n = bit_dec;
                            sdi_n = stream[bit_dec];
                        end
                    end
                end
            end
            DONE: begin
                if (primed) begin
                    dout_n    = shreg;
                    dout_ch_n = cur_ch;
                    valid_n   = 1'b1;
                end
                cur_n    = nxt_ch;
                primed_n = 1'b1;
                nxt_n    = next_set(ch_mask, nxt_ch);
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase

        pending_n = pending;
        if (take) pending_n = 1'b0;
        if (tick) pending_n = 1'b1;
        overrun_n = tick & pending & ~take;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            tmr        <= '0;
            bit_idx    <= '0;
            ph         <= 1'b0;
            shreg      <= '0;
            cfg_q      <= '0;
            cur_ch     <= '0;
            nxt_ch     <= '0;
            primed     <= 1'b0;
            pending    <= 1'b0;
            adc_convst <= 1'b0;
            adc_sck    <= 1'b0;
            adc_sdi    <= 1'b0;
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            tmr        <= tmr_n;
            bit_idx    <= bit_n;
            ph         <= ph_n;
            shreg      <= shreg_n;
            cfg_q      <= cfg_n;
            cur_ch     <= cur_n;
            nxt_ch     <= nxt_n;
            primed     <= primed_n;
            pending    <= pending_n;
            adc_convst <= convst_n;
            adc_sck    <= sck_n;
            adc_sdi    <= sdi_n;
            dout       <= dout_n;
            dout_ch    <= dout_ch_n;
            dout_valid <= valid_n;
            overrun    <= overrun_n;
        end
    end

endmodule
